// File: rtl/usb_pkg.sv
// Shared USB constants for the serial interface engine: PIDs, PID types, CRC parameters, decoder states.
// Pure declarations; no latency or backpressure.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [1:0] PT_SPECIAL = 2'b00;
  localparam logic [1:0] PT_TOKEN   = 2'b01;
  localparam logic [1:0] PT_HSK     = 2'b10;
  localparam logic [1:0] PT_DATA    = 2'b11;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'h0C;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_DATA,
    ST_HSK,
    ST_DROP
  } state_e;

endpackage

// File: rtl/usb_crc.sv
// Byte-wide CRC update, bits consumed LSB first, generic width/polynomial.
// Purely combinational (zero latency); no backpressure.
module usb_crc #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic [WIDTH-1:0] crc_i,
  input  logic [7:0]       data_i,
  output logic [WIDTH-1:0] crc_o
);

  logic [WIDTH-1:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[WIDTH-1] ^ data_i[i]) begin
        c = {c[WIDTH-2:0], 1'b0} ^ POLY;
      end else begin
        c = {c[WIDTH-2:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/sie_rx.sv
// USB receive packet decoder: PID check, token fields, CRC5/CRC16, payload with CRC stripped, EOP verdict.
// Strobes register one cycle after the PHY event; no backpressure, PHY events are always consumed.
module sie_rx
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_err_i,
  input  logic        rx_ready_i,
  input  logic        usb_reset_i,
  output logic [3:0]  pid_o,
  output logic [6:0]  addr_o,
  output logic [3:0]  endp_o,
  output logic [10:0] frame_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        pkt_start_o,
  output logic        pkt_end_o,
  output logic        pkt_ok_o
);

  localparam int             CW      = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BYTES);

  state_e         state_q, state_d;
  logic [4:0]     crc5_q, crc5_d, crc5_nxt;
  logic [15:0]    crc16_q, crc16_d, crc16_nxt;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     fill_q, fill_d;
  logic [7:0]     dly0_q, dly0_d, dly1_q, dly1_d;
  logic [3:0]     pid_q, pid_d;
  logic [6:0]     addr_q, addr_d;
  logic [3:0]     endp_q, endp_d;
  logic [10:0]    frame_q, frame_d;
  logic [7:0]     data_q, data_d;
  logic           data_valid_q, data_valid_d;
  logic           pkt_start_q, pkt_start_d;
  logic           pkt_end_q, pkt_end_d;
  logic           pkt_ok_q, pkt_ok_d;

  logic byte_ev, err_ev, eop_ev, pid_ok;

  assign byte_ev = rx_ready_i & rx_valid_i;
  assign err_ev  = rx_ready_i & ~rx_valid_i & rx_err_i;
  assign eop_ev  = rx_ready_i & ~rx_valid_i & ~rx_err_i;
  assign pid_ok  = (rx_data_i[7:4] == ~rx_data_i[3:0]) && (rx_data_i[1:0] != PT_SPECIAL);

  usb_crc #(.WIDTH(5), .POLY(CRC5_POLY)) u_crc5 (
    .crc_i  (crc5_q),
    .data_i (rx_data_i),
    .crc_o  (crc5_nxt)
  );

  usb_crc #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
    .crc_i  (crc16_q),
    .data_i (rx_data_i),
    .crc_o  (crc16_nxt)
  );

  always_comb begin
    state_d      = state_q;
    crc5_d       = crc5_q;
    crc16_d      = crc16_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    dly0_d       = dly0_q;
    dly1_d       = dly1_q;
    pid_d        = pid_q;
    addr_d       = addr_q;
    endp_d       = endp_q;
    frame_d      = frame_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_end_d    = 1'b0;
    pkt_ok_d     = 1'b0;

    if (usb_reset_i) begin
      state_d = ST_IDLE;
      crc5_d  = CRC5_INIT;
      crc16_d = CRC16_INIT;
      cnt_d   = '0;
      fill_d  = 2'd0;
      dly0_d  = 8'h00;
      dly1_d  = 8'h00;
      pid_d   = 4'h0;
      addr_d  = 7'h00;
      endp_d  = 4'h0;
      frame_d = 11'h000;
    end else if (byte_ev) begin
      case (state_q)
        ST_IDLE: begin
          crc5_d  = CRC5_INIT;
          crc16_d = CRC16_INIT;
          cnt_d   = '0;
          fill_d  = 2'd0;
          if (pid_ok) begin
            pid_d       = rx_data_i[3:0];
            pkt_start_d = 1'b1;
            case (rx_data_i[1:0])
              PT_TOKEN: state_d = ST_TOKEN;
              PT_DATA:  state_d = ST_DATA;
              default:  state_d = ST_HSK;
            endcase
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_TOKEN: begin
          // The delay line doubles as token byte storage: dly1 = byte1, dly0 = byte2.
          if (fill_q == 2'd2) begin
            state_d = ST_DROP;
          end else begin
            crc5_d = crc5_nxt;
            dly1_d = dly0_q;
            dly0_d = rx_data_i;
            fill_d = fill_q + 2'd1;
          end
        end
        ST_DATA: begin
          if (fill_q == 2'd2 && cnt_q == MAX_CNT) begin
            state_d = ST_DROP;
          end else begin
            crc16_d = crc16_nxt;
            dly1_d  = dly0_q;
            dly0_d  = rx_data_i;
            if (fill_q == 2'd2) begin
              data_d       = dly1_q;
              data_valid_d = 1'b1;
              cnt_d        = cnt_q + 1'b1;
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end
        end
        ST_HSK:  state_d = ST_DROP;
        default: ;
      endcase
    end else if ((eop_ev || err_ev) && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      pkt_end_d = 1'b1;
      if (eop_ev) begin
        case (state_q)
          ST_TOKEN: begin
            pkt_ok_d = (fill_q == 2'd2) && (crc5_q == CRC5_RESID);
            if (pkt_ok_d) begin
              addr_d  = dly1_q[6:0];
              endp_d  = {dly0_q[2:0], dly1_q[7]};
              frame_d = {dly0_q[2:0], dly1_q};
            end
          end
          ST_DATA: pkt_ok_d = (fill_q == 2'd2) && (crc16_q == CRC16_RESID);
          ST_HSK:  pkt_ok_d = 1'b1;
          default: pkt_ok_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      crc5_q       <= CRC5_INIT;
      crc16_q      <= CRC16_INIT;
      cnt_q        <= '0;
      fill_q       <= 2'd0;
      dly0_q       <= 8'h00;
      dly1_q       <= 8'h00;
      pid_q        <= 4'h0;
      addr_q       <= 7'h00;
      endp_q       <= 4'h0;
      frame_q      <= 11'h000;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc5_q       <= crc5_d;
      crc16_q      <= crc16_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      dly0_q       <= dly0_d;
      dly1_q       <= dly1_d;
      pid_q        <= pid_d;
      addr_q       <= addr_d;
      endp_q       <= endp_d;
      frame_q      <= frame_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      pkt_start_q  <= pkt_start_d;
      pkt_end_q    <= pkt_end_d;
      pkt_ok_q     <= pkt_ok_d;
    end
  end

  assign pid_o        = pid_q;
  assign addr_o       = addr_q;
  assign endp_o       = endp_q;
  assign frame_o      = frame_q;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign pkt_start_o  = pkt_start_q;
  assign pkt_end_o    = pkt_end_q;
  assign pkt_ok_o     = pkt_ok_q;

endmodule

// File: tb/tb_sie_rx.sv
// Scoreboard bench for sie_rx: a packet-level model queues expected strobes, a monitor pops and compares.
// Packets are built with generator-style CRCs (inverted, MSB first), independent of the residual check.
module tb_sie_rx;

  localparam int MAXB = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;   // 0 start, 1 data, 2 end
    logic [7:0]  val;
    logic        ok;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_err, rx_ready, usb_reset;
  logic [3:0]  pid_o, endp_o;
  logic [6:0]  addr_o;
  logic [10:0] frame_o;
  logic [7:0]  data_o;
  logic        data_valid_o, pkt_start_o, pkt_end_o, pkt_ok_o;

  exp_t        expq[$];
  exp_t        e;
  int          nchk = 0;
  int          npass = 0;
  logic [3:0]  m_pid = 4'h0;
  logic [6:0]  m_addr = 7'h0;
  logic [3:0]  m_endp = 4'h0;
  logic [10:0] m_frame = 11'h0;

  always #5 clk = ~clk;

  sie_rx #(.MAX_BYTES(MAXB)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_err_i     (rx_err),
    .rx_ready_i   (rx_ready),
    .usb_reset_i  (usb_reset),
    .pid_o        (pid_o),
    .addr_o       (addr_o),
    .endp_o       (endp_o),
    .frame_o      (frame_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .pkt_start_o  (pkt_start_o),
    .pkt_end_o    (pkt_end_o),
    .pkt_ok_o     (pkt_ok_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] crc5_gen(input logic [10:0] f);
    logic [4:0] c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      logic fb = c[4] ^ f[i];
      c = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] tok_b2(input logic [10:0] f);
    logic [4:0] c = crc5_gen(f);
    logic [7:0] b2;
    b2[2:0] = f[10:8];
    for (int i = 0; i < 5; i++) b2[3+i] = ~c[4-i];
    return b2;
  endfunction

  // Returns {first trailer byte, second trailer byte}.
  function automatic logic [15:0] crc16_trailer(input bq_t p);
    logic [15:0] c = 16'hFFFF;
    logic [7:0]  lo, hi;
    foreach (p[k]) begin
      for (int j = 0; j < 8; j++) begin
        logic fb = c[15] ^ p[k][j];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    for (int i = 0; i < 8; i++) begin
      lo[i] = ~c[15-i];
      hi[i] = ~c[7-i];
    end
    return {lo, hi};
  endfunction

  function automatic bq_t mk_tok(input logic [3:0] pid, input logic [10:0] f);
    bq_t b;
    b.push_back({~pid, pid});
    b.push_back(f[7:0]);
    b.push_back(tok_b2(f));
    return b;
  endfunction

  function automatic bq_t mk_data(input logic [3:0] pid, input int len);
    bq_t b, p;
    logic [15:0] t;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    t = crc16_trailer(p);
    b.push_back({~pid, pid});
    foreach (p[i]) b.push_back(p[i]);
    b.push_back(t[15:8]);
    b.push_back(t[7:0]);
    return b;
  endfunction

  task automatic push(input int kind, input logic [7:0] val, input logic ok);
    exp_t x;
    x.kind = kind; x.val = val; x.ok = ok;
    x.pid = m_pid; x.addr = m_addr; x.endp = m_endp; x.frame = m_frame;
    expq.push_back(x);
  endtask

  task automatic model_pkt(input bq_t b, input bit err);
    logic [7:0]  pid = b[0];
    int          n = b.size() - 1;
    logic        ok = 1'b0;
    logic [10:0] f;
    logic [7:0]  b2, b2exp;
    bq_t         p;
    logic [15:0] t;
    if (!(pid[7:4] == ~pid[3:0] && pid[1:0] != 2'b00)) begin
      push(2, 8'h00, 1'b0);
      return;
    end
    m_pid = pid[3:0];
    push(0, 8'h00, 1'b0);
    case (pid[1:0])
      2'b01: begin
        if (n == 2) begin
          f = {b[2][2:0], b[1]};
          b2 = b[2];
          b2exp = tok_b2(f);
          ok = (b2 == b2exp);
          if (ok && !err) begin
            m_addr = f[6:0]; m_endp = f[10:7]; m_frame = f;
          end
        end
      end
      2'b11: begin
        if (n >= 2) begin
          for (int i = 1; i <= n - 2; i++) p.push_back(b[i]);
          for (int i = 0; i < p.size() && i < MAXB; i++) push(1, p[i], 1'b0);
          t = crc16_trailer(p);
          ok = (p.size() <= MAXB) && (b[n-1] == t[15:8]) && (b[n] == t[7:0]);
        end
      end
      default: ok = (n == 0);
    endcase
    push(2, 8'h00, ok && !err);
  endtask

  // ---------------- stimulus ----------------
  task automatic ev(input logic v, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v; rx_err = er; rx_data = d; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_pkt(input bq_t b, input bit err);
    model_pkt(b, err);
    foreach (b[i]) ev(1'b1, 1'b0, b[i]);
    if (err) ev(1'b0, 1'b1, 8'($urandom));
    else     ev(1'b0, 1'b0, 8'($urandom));
    rx_valid = 1'b0;
  endtask

  task automatic corrupt(inout bq_t b);
    int idx = $urandom_range(1, b.size() - 1);
    logic [7:0] tmp = b[idx];
    tmp[$urandom_range(0, 7)] ^= 1'b1;
    b[idx] = tmp;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn && (pkt_start_o || data_valid_o || pkt_end_o)) begin
      if (expq.size() == 0) begin
        chk("unexpected_strobe", {pkt_start_o, data_valid_o, pkt_end_o}, 3'b000);
      end else begin
        e = expq.pop_front();
        chk("strobe_kind", {pkt_start_o, data_valid_o, pkt_end_o}, 3'b100 >> e.kind);
        case (e.kind)
          0: chk("start_pid", pid_o, e.pid);
          1: chk("data_byte", data_o, e.val);
          default: begin
            chk("pkt_ok", pkt_ok_o, e.ok);
            chk("fields_pid_addr_endp_frame", {pid_o, addr_o, endp_o, frame_o},
                {e.pid, e.addr, e.endp, e.frame});
          end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget, expq=%0d", expq.size());
    $fatal(1);
  end

  initial begin
    bq_t b;
    logic [3:0] tp[4] = '{4'h1, 4'h9, 4'h5, 4'hD};
    logic [3:0] hp[3] = '{4'h2, 4'hA, 4'hE};
    logic [7:0] r;
    rstn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    rx_ready = 1'b0; usb_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pid_o, addr_o, endp_o, frame_o, data_o, data_valid_o,
                          pkt_start_o, pkt_end_o, pkt_ok_o}, 64'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send_pkt('{8'h2D, 8'h00, 8'h10}, 1'b0);
    send_pkt('{8'h2D, 8'h00, 8'h11}, 1'b0);
    send_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00,
               8'hDD, 8'h94}, 1'b0);
    send_pkt('{8'h4B, 8'h00, 8'h00}, 1'b0);
    send_pkt('{8'hD2}, 1'b0);
    send_pkt('{8'hD2, 8'h00}, 1'b0);
    send_pkt('{8'h2C, 8'h11, 8'h22}, 1'b0);
    send_pkt('{8'hC3, 8'h01, 8'h02, 8'h03}, 1'b1);
    send_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00,
               8'hDD, 8'h94}, 1'b0);
    send_pkt(mk_tok(4'h1, 11'h5A3), 1'b0);

    // Bus reset after the 4th byte of a DATA packet: one payload byte out, then silence.
    b = mk_data(4'h3, 6);
    m_pid = 4'h3;
    push(0, 8'h00, 1'b0);
    push(1, b[1], 1'b0);
    for (int i = 0; i < 4; i++) ev(1'b1, 1'b0, b[i]);
    repeat (3) @(negedge clk);
    usb_reset = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    usb_reset = 1'b0;
    m_pid = 4'h0; m_addr = 7'h0; m_endp = 4'h0; m_frame = 11'h0;
    chk("usbrst_fields", {pid_o, addr_o, endp_o, frame_o}, 26'h0);
    chk("usbrst_queue_drained", expq.size(), 0);
    ev(1'b0, 1'b0, 8'h00);
    send_pkt(mk_tok(4'h5, 11'h7FE), 1'b0);

    // Asynchronous reset mid-packet.
    b = mk_data(4'hB, 5);
    m_pid = 4'hB;
    push(0, 8'h00, 1'b0);
    push(1, b[1], 1'b0);
    for (int i = 0; i < 4; i++) ev(1'b1, 1'b0, b[i]);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_outputs", {pid_o, addr_o, endp_o, frame_o, data_o, data_valid_o,
                                pkt_start_o, pkt_end_o, pkt_ok_o}, 64'h0);
    m_pid = 4'h0; m_addr = 7'h0; m_endp = 4'h0; m_frame = 11'h0;
    @(negedge clk);
    rstn = 1'b1; rx_valid = 1'b0;
    ev(1'b0, 1'b0, 8'h00);
    send_pkt(mk_tok(4'hD, 11'h123), 1'b0);

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 4))
        0: begin
          b = mk_tok(tp[$urandom_range(0, 3)], 11'($urandom));
          if ($urandom_range(0, 3) == 0) corrupt(b);
          if ($urandom_range(0, 9) == 0) b.push_back(8'($urandom));
        end
        1: begin
          if ($urandom_range(0, 7) == 0) begin
            b = '{8'hC3, 8'($urandom)};
          end else begin
            b = mk_data($urandom_range(0, 1) ? 4'hB : 4'h3, $urandom_range(0, MAXB + 2));
            if ($urandom_range(0, 3) == 0) corrupt(b);
          end
        end
        2: begin
          r = {4'h0, hp[$urandom_range(0, 2)]};
          b = '{{~r[3:0], r[3:0]}};
          if ($urandom_range(0, 4) == 0) b.push_back(8'($urandom));
        end
        3: begin
          do r = 8'($urandom); while (r[7:4] == ~r[3:0]);
          b = '{r};
          repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
        end
        default: begin
          b = '{$urandom_range(0, 1) ? 8'h3C : 8'hF0};
          repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
        end
      endcase
      send_pkt(b, $urandom_range(0, 9) == 0);
    end

    repeat (10) @(negedge clk);
    chk("exp_queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
